// File: rtl/rgb_binarize.sv
// Three-stage RGB-to-gray binarizer with a per-frame threshold that is either
// manual or derived from the previous frame's gray min/max midpoint.
module rgb_binarize #(
    parameter int IMG_W    = 200,
    parameter int IMG_H    = 164,
    parameter int THR_INIT = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_rgb,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic        i_thr_sel,
    input  logic [7:0]  i_thr_manual,
    output logic [23:0] o_binary,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [7:0]  o_thr,
    output logic        o_frame_err
);

    localparam logic [16:0] FRAME_PIX = 17'(IMG_W * IMG_H);
    localparam logic [7:0]  THR_RST   = 8'(THR_INIT);

    logic [15:0] prod_r, prod_g, prod_b;
    logic [15:0] sum;
    logic [7:0]  gray;
    logic [2:0]  hs_pipe, vs_pipe, de_pipe;
    logic        frame_start;
    logic        stat_de;

    logic [7:0]  gmin, gmax;
    logic [16:0] pcnt;
    logic        frame_ok;
    logic [8:0]  adapt_sum;

    logic        sel_lat;
    logic [7:0]  manual_lat;
    logic [7:0]  thr_adapt;
    logic        thr_valid;

    assign gray        = sum[15:8];
    assign frame_start = i_vsync & ~vs_pipe[0];
    // de_pipe[1] travels with the sample whose gray is being binarized now
    assign stat_de     = de_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            sum      <= '0;
            o_binary <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
            de_pipe  <= '0;
        end else begin
            prod_r   <= 16'(i_rgb[23:16]) * 16'd77;
            prod_g   <= 16'(i_rgb[15:8])  * 16'd150;
            prod_b   <= 16'(i_rgb[7:0])   * 16'd29;
            sum      <= prod_r + prod_g + prod_b;
            o_binary <= (gray < o_thr) ? 24'h000000 : 24'hFFFFFF;
            hs_pipe  <= {hs_pipe[1:0], i_hsync};
            vs_pipe  <= {vs_pipe[1:0], i_vsync};
            de_pipe  <= {de_pipe[1:0], i_de};
        end
    end

    assign o_hsync = hs_pipe[2];
    assign o_vsync = vs_pipe[2];
    assign o_de    = de_pipe[2];

    // A sample landing on the boundary cycle seeds the new frame's statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gmin <= 8'hFF;
            gmax <= 8'h00;
            pcnt <= '0;
        end else if (frame_start) begin
            gmin <= stat_de ? gray : 8'hFF;
            gmax <= stat_de ? gray : 8'h00;
            pcnt <= stat_de ? 17'd1 : 17'd0;
        end else if (stat_de) begin
            if (gray < gmin) gmin <= gray;
            if (gray > gmax) gmax <= gray;
            if (pcnt != '1)  pcnt <= pcnt + 17'd1;
        end
    end

    always_comb begin
        frame_ok  = (pcnt == FRAME_PIX);
        adapt_sum = {1'b0, gmin} + {1'b0, gmax} + 9'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_lat     <= 1'b0;
            manual_lat  <= '0;
            thr_adapt   <= THR_RST;
            thr_valid   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= frame_start & ~frame_ok;
            if (frame_start) begin
                sel_lat    <= i_thr_sel;
                manual_lat <= i_thr_manual;
                if (frame_ok) begin
                    thr_adapt <= adapt_sum[8:1];
                    thr_valid <= 1'b1;
                end
            end
        end
    end

    // Every source here only changes at a boundary, so o_thr is frame-stable.
    always_comb begin
        o_thr = THR_RST;
        if (sel_lat)
            o_thr = manual_lat;
        else if (thr_valid)
            o_thr = thr_adapt;
    end

endmodule

// File: tb/tb_rgb_binarize.sv
// Randomized scoreboard bench for rgb_binarize on a reduced 16x10 frame,
// with a frame-level reference model of the threshold logic.
module tb_rgb_binarize;

    localparam int W    = 16;
    localparam int H    = 10;
    localparam int NPIX = W * H;
    localparam int THR0 = 128;

    logic        clk;
    logic        rst_n;
    logic [23:0] i_rgb;
    logic        i_hsync, i_vsync, i_de;
    logic        i_thr_sel;
    logic [7:0]  i_thr_manual;
    logic [23:0] o_binary;
    logic        o_hsync, o_vsync, o_de;
    logic [7:0]  o_thr;
    logic        o_frame_err;

    rgb_binarize #(.IMG_W(W), .IMG_H(H), .THR_INIT(THR0)) dut (
        .clk(clk), .rst_n(rst_n), .i_rgb(i_rgb),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .i_thr_sel(i_thr_sel), .i_thr_manual(i_thr_manual),
        .o_binary(o_binary), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_thr(o_thr), .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [23:0] exp;
        int          cyc;
    } sb_t;

    sb_t      sb_q[$];
    bit [2:0] hist[0:4095];
    int       rel_cyc = 1 << 30;
    int       n_compared = 0;
    int       n_mismatched = 0;

    // Reference model: frame statistics and the threshold the frame should use.
    int m_count, m_min, m_max, m_adapt, m_thr;
    bit m_valid;
    bit m_err;

    task automatic model_reset();
        m_count = 0; m_min = 255; m_max = 0;
        m_valid = 0; m_adapt = THR0; m_thr = THR0;
    endtask

    task automatic model_boundary(input bit sel, input int man);
        m_err = (m_count != NPIX);
        if (!m_err) begin
            m_adapt = (m_min + m_max + 1) / 2;
            m_valid = 1;
        end
        m_thr   = sel ? man : (m_valid ? m_adapt : THR0);
        m_count = 0; m_min = 255; m_max = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] rgb, input logic hs, input logic vs, input logic de);
        int  g;
        sb_t e;
        i_rgb = rgb; i_hsync = hs; i_vsync = vs; i_de = de;
        hist[cyc % 4096] = {hs, vs, de};
        if (de && rst_n) begin
            g = (int'(rgb[23:16]) * 77 + int'(rgb[15:8]) * 150 + int'(rgb[7:0]) * 29) / 256;
            e.exp = (g < m_thr) ? 24'h000000 : 24'hFFFFFF;
            e.cyc = cyc;
            sb_q.push_back(e);
            m_count++;
            if (g < m_min) m_min = g;
            if (g > m_max) m_max = g;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] make_pixel(input int mode, input int idx);
        logic [7:0] g;
        case (mode)
            1: begin
                if (idx == 0)      g = 8'd20;
                else if (idx == 1) g = 8'd220;
                else               g = 8'($urandom_range(220, 20));
                return {g, g, g};
            end
            2: begin
                g = 8'(127 + idx % 3);
                return {g, g, g};
            end
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic send_vsync(input bit sel, input logic [7:0] man);
        i_thr_sel = sel; i_thr_manual = man;
        applyStimulus(24'h0, 1'b0, 1'b1, 1'b0);
        model_boundary(sel, int'(man));
        checkOutput("thr_at_boundary", 32'(o_thr), m_thr);
        checkOutput("frame_err_pulse", 32'(o_frame_err), 32'(m_err));
        applyStimulus(24'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("frame_err_width", 32'(o_frame_err), 0);
    endtask

    task automatic do_mid_reset();
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        checkOutput("rst_binary", 32'(o_binary), 0);
        checkOutput("rst_timing", 32'({o_hsync, o_vsync, o_de}), 0);
        checkOutput("rst_thr", 32'(o_thr), THR0);
        checkOutput("rst_frame_err", 32'(o_frame_err), 0);
        repeat (3) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic run_frame(input int lines, input int mode, input bit sel,
                             input logic [7:0] man, input logic [7:0] mid_man, input int rst_line);
        send_vsync(sel, man);
        repeat (3) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            if (l == lines / 2) i_thr_manual = mid_man;
            if (l == rst_line) begin
                do_mid_reset();
                repeat (4) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
                return;
            end
            for (int p = 0; p < W; p++)
                applyStimulus(make_pixel(mode, l * W + p), 1'b0, 1'b0, 1'b1);
            repeat (3) applyStimulus(24'h0, 1'b1, 1'b0, 1'b0);
        end
        repeat (5) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: timing alignment every cycle, pixel results whenever o_de is high.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (cyc - 3 >= rel_cyc)
                checkOutput("timing_delay", 32'({o_hsync, o_vsync, o_de}), 32'(hist[(cyc - 3) % 4096]));
            if (o_de) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_pixel at cycle %0d: got %0h, expected none", cyc, o_binary);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("binary", 32'(o_binary), 32'(e.exp));
                    checkOutput("latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        i_rgb = '0; i_hsync = 0; i_vsync = 0; i_de = 0;
        i_thr_sel = 0; i_thr_manual = '0;
        model_reset();
        repeat (3) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("init_binary", 32'(o_binary), 0);
        checkOutput("init_de", 32'(o_de), 0);
        checkOutput("init_thr", 32'(o_thr), THR0);
        checkOutput("init_frame_err", 32'(o_frame_err), 0);
        rst_n = 1'b1;
        rel_cyc = cyc;
        repeat (2) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] first boundary with manual 100, then single-pixel latency");
        send_vsync(1'b1, 8'd100);
        repeat (3) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(24'h808080, 1'b0, 1'b0, 1'b1);
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_early_de", 32'(o_de), 0);
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_de", 32'(o_de), 1);
        checkOutput("latency_binary", 32'(o_binary), 32'h00FFFFFF);
        repeat (5) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] threshold edge frame, manual 128");
        run_frame(H, 2, 1'b1, 8'd128, 8'd128, -1);
        $display("[TB] gray 20..220 frame, adaptive");
        run_frame(H, 1, 1'b0, 8'd0, 8'd0, -1);
        $display("[TB] short frame");
        run_frame(H - 1, 0, 1'b0, 8'd0, 8'd0, -1);
        checkOutput("adapt_thr_120", 32'(o_thr), 120);
        run_frame(H, 0, 1'b0, 8'd0, 8'd0, -1);
        checkOutput("short_keeps_thr", 32'(o_thr), 120);
        $display("[TB] mid-frame manual switch 50 -> 200");
        run_frame(H, 0, 1'b1, 8'd50, 8'd200, -1);
        checkOutput("no_tearing", 32'(o_thr), 50);
        run_frame(H, 0, 1'b1, 8'd200, 8'd200, -1);
        checkOutput("next_frame_manual", 32'(o_thr), 200);
        $display("[TB] reset during line %0d", H / 2);
        run_frame(H, 0, 1'b0, 8'd0, 8'd0, H / 2);
        run_frame(H, 0, 1'b0, 8'd0, 8'd0, -1);
        checkOutput("post_reset_thr", 32'(o_thr), THR0);
        run_frame(H, 0, 1'b0, 8'd0, 8'd0, -1);
        send_vsync(1'b0, 8'd0);
        repeat (6) applyStimulus(24'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rgb_binarize.md
RGB_BINARIZE -- requirements
Module: rgb_binarize

Interface
REQ-001 SHALL have parameter IMG_W, default 200: active pixels per line.
REQ-002 SHALL have parameter IMG_H, default 164: active lines per frame.
REQ-003 SHALL have parameter THR_INIT, default 128: threshold used until the first adaptive threshold is latched.
REQ-004 Ports SHALL be:
- clk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- i_rgb  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
- i_hsync, i_vsync, i_de  input  1 each  video timing; i_vsync active-high.
- i_thr_sel  input  1  0 = adaptive threshold, 1 = manual threshold.
- i_thr_manual  input  8  manual threshold.
- o_binary  output  24  24'h000000 (object/dark) or 24'hFFFFFF (background).
- o_hsync, o_vsync, o_de  output  1 each  timing aligned to o_binary.
- o_thr  output  8  threshold applied to the current frame.
- o_frame_err  output  1  one-cycle pulse when a frame has a bad pixel count.

Function
REQ-005 Stage 1 SHALL register the products R*77, G*150 and B*29, each 16 bits unsigned.
REQ-006 Stage 2 SHALL register the 16-bit sum of the stage-1 products; no overflow is possible (max 65280).
REQ-007 Stage 3 SHALL compute gray = sum[15:8]. It SHALL register o_binary = 24'h000000 if gray < o_thr, else 24'hFFFFFF; gray == o_thr gives FFFFFF.
REQ-008 Pixel latency i_rgb -> o_binary SHALL be exactly 3 cycles.
REQ-009 i_hsync, i_vsync and i_de SHALL each pass through a 3-stage register delay so they stay aligned with o_binary.
REQ-010 A frame boundary SHALL be the cycle where i_vsync = 1 and its registered previous value = 0 (rising edge).
REQ-011 Per-frame statistics SHALL be updated only on cycles where the stage-3 delayed de is 1:
- gmin: running minimum of gray.
- gmax: running maximum of gray.
- pcnt: 17-bit pixel count, saturating at 2^17-1.
REQ-012 At each frame boundary the block SHALL:
- evaluate the finished frame (REQ-013);
- reset gmin to 255, gmax to 0 and pcnt to 0;
- latch i_thr_sel and i_thr_manual for the new frame.
REQ-013 When a frame is evaluated:
- If pcnt == IMG_W*IMG_H: set thr_adapt = (gmin + gmax + 1) >> 1, using a 9-bit intermediate; thr_valid becomes 1.
- Otherwise: pulse o_frame_err for one cycle; thr_adapt is unchanged.
REQ-014 o_thr SHALL be updated only at a frame boundary, taking effect on the first cycle after it:
- latched sel = 1: o_thr = latched manual value;
- latched sel = 0 and thr_valid = 1: o_thr = thr_adapt;
- otherwise: o_thr = THR_INIT.
REQ-015 Changes on i_thr_sel or i_thr_manual in mid-frame SHALL have no effect until the next frame boundary; there is no tearing inside a frame.
REQ-016 A pixel whose delayed de coincides with the boundary cycle SHALL count toward the new frame: the statistics reset and the first new sample merge in that cycle.
REQ-017 The first boundary after reset SHALL evaluate a partial or empty frame. It SHALL pulse o_frame_err unless pcnt happens to equal IMG_W*IMG_H.
REQ-018 A frame of all-identical gray value g SHALL give thr_adapt = g.

Reset
REQ-019 While rst_n = 0, all pipeline registers SHALL be 0:
- o_binary = 0; o_hsync, o_vsync, o_de = 0;
- o_frame_err = 0;
- o_thr = THR_INIT; thr_adapt = THR_INIT; thr_valid = 0;
- gmin = 255, gmax = 0, pcnt = 0; latched sel/manual = 0.
REQ-020 Reset asserted mid-frame SHALL discard all statistics. The frame after release is treated per REQ-017.

Verification
REQ-021 Latency: reset release, manual threshold 100, pixel i_rgb = 24'h808080 with de = 1 -> gray = 128, o_binary = FFFFFF exactly 3 cycles later, o_de aligned.
REQ-022 Threshold edge: manual threshold 128, gray inputs 127, 128, 129 -> o_binary 000000, FFFFFF, FFFFFF.
REQ-023 Adaptive: a full 200x164 frame with gray 20..220 present, sel = 0 -> after the next vsync rise o_thr = 120 and o_frame_err = 0.
REQ-024 Short frame: a frame with 200x163 valid pixels -> o_frame_err high for exactly 1 cycle; o_thr keeps its previous value.
REQ-025 Mid-frame switch: i_thr_manual changed from 50 to 200 halfway through a frame -> o_binary in that frame still uses 50; the next frame uses 200.
REQ-026 Reset mid-frame: assert rst_n during line 80 -> o_thr = THR_INIT and outputs 0. The first boundary after release pulses o_frame_err, and the next full frame restores adaptive operation.
